axi4_lite_read_arbiter: RTL and testbench

Shares one AXI4-Lite read master port (AR/R channels) between NUM_REQ local requesters using round-robin arbitration.
- One outstanding read at a time.
- Sequences the AR and R handshakes.
- Returns data/response to the granted requester.
- Guards against a hung slave with an RVALID timeout.

Sits between the per-agent request logic and the AXI4-Lite read interface of the master VIP/DUT.

---
 rtl/axi4_lite_read_arb_pkg.sv | 11 +
 rtl/axi4_lite_rr_picker.sv | 29 ++
 rtl/axi4_lite_read_arbiter.sv | 91 +++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_read_arb_pkg.sv
// axi4_lite_read_arb_pkg: shared types, response codes and width helper for the read arbiter
package axi4_lite_read_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_enum;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic int grant_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi4_lite_rr_picker.sv
// axi4_lite_rr_picker: combinational round-robin winner search starting after last
module axi4_lite_rr_picker
  import axi4_lite_read_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any_valid
);
  logic [IW-1:0] cand;
  always_comb begin
    grant = '0;
    index = '0;
    any_valid = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(last) + 1 + k) % NUM_REQ);
      if (req[cand]) begin
        index = cand;
        any_valid = 1'b1;
      end
    end
    grant[index] = any_valid;
  end
endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// axi4_lite_read_arbiter: round-robin sharing of one AXI4-Lite read port with rvalid timeout
module axi4_lite_read_arbiter
  import axi4_lite_read_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RVALID_TIMEOUT = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]       req_prot,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_resp,
  output logic                       rsp_timeout,
  output logic                       stray_err,
  output logic [ADDRESS_WIDTH-1:0]   araddr,
  output logic [2:0]                 arprot,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  output logic                       rready
);
  localparam int GW = grant_width(NUM_REQ);
  localparam int CW = RVALID_TIMEOUT > 0 ? $clog2(RVALID_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RVALID_TIMEOUT > 0 ? RVALID_TIMEOUT - 1 : 0);
  arb_state_enum state, state_nx;
  logic [GW-1:0] last, grant, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic pick_any, timed_out;
  logic [CW-1:0] cnt;
  axi4_lite_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(req_valid),
    .last(last),
    .grant(pick_grant),
    .index(pick_idx),
    .any_valid(pick_any)
  );
  assign timed_out = RVALID_TIMEOUT > 0 && state == DATA && !rvalid && cnt == CNT_LAST;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      last <= GW'(NUM_REQ - 1);
      grant <= '0;
      araddr <= '0;
      arprot <= '0;
      cnt <= '0;
      rsp_data <= '0;
      rsp_resp <= RESP_OKAY;
      rsp_timeout <= 1'b0;
      stray_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) begin
        grant <= pick_idx;
        last <= pick_idx;
        araddr <= req_addr[pick_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        arprot <= req_prot[pick_idx*3 +: 3];
      end
      if (state == ADDR) cnt <= '0;
      else if (RVALID_TIMEOUT > 0 && state == DATA && !rvalid) cnt <= cnt + 1'b1;
      if (state == DATA && (rvalid || timed_out)) begin
        rsp_data <= rvalid ? rdata : '0;
        rsp_resp <= rvalid ? rresp : RESP_SLVERR;
        rsp_timeout <= !rvalid;
      end
      if (rvalid && (state == IDLE || state == RESP)) stray_err <= 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = pick_any ? ADDR : IDLE;
      ADDR: state_nx = arready ? DATA : ADDR;
      DATA: state_nx = (rvalid || timed_out) ? RESP : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE ? pick_grant : '0;
    arvalid = state == ADDR;
    rready = state != ADDR;
    rsp_valid = state == RESP ? NUM_REQ'(1) << grant : '0;
  end
endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb_axi4_lite_read_arbiter: scoreboard-driven scenario bench for the read arbiter
module tb_axi4_lite_read_arbiter;
  import axi4_lite_read_arb_pkg::*;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  typedef struct {
    logic [N-1:0]  onehot;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          to;
  } exp_t;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*3-1:0] req_prot = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] rdata = '0;
  logic [1:0] rsp_resp;
  logic [1:0] rresp = '0;
  logic rsp_timeout, stray_err, arvalid, rready;
  logic arready = 1'b0;
  logic rvalid = 1'b0;
  logic [AW-1:0] araddr;
  logic [2:0] arprot;
  int n_checks = 0;
  int n_fail = 0;
  int ar_count = 0;
  exp_t sb[$];
  axi4_lite_read_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RVALID_TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_addr(req_addr), .req_prot(req_prot), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .stray_err(stray_err),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) if (!areset && arvalid && arready) ar_count <= ar_count + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end
  task automatic do_reset();
    areset = 1'b1;
    req_valid = '0;
    arready = 1'b0;
    rvalid = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [2:0] p);
    req_addr[i*AW +: AW] = a;
    req_prot[i*3 +: 3] = p;
    req_valid[i] = 1'b1;
  endtask
  task automatic do_ar(input int delay, output logic [AW-1:0] a, output logic [2:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge aclk);
      ok = arvalid;
    end
    a = araddr;
    p = arprot;
    repeat (delay) @(negedge aclk);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
  endtask
  task automatic do_r(input int delay, input logic [DW-1:0] d, input logic [1:0] r);
    repeat (delay) @(negedge aclk);
    rvalid = 1'b1;
    rdata = d;
    rresp = r;
    @(negedge aclk);
    rvalid = 1'b0;
  endtask
  task automatic wait_rsp(output int steps, output bit ok);
    ok = 1'b0;
    steps = 0;
    while (!ok && steps < 40) begin
      ok = |rsp_valid;
      if (!ok) begin
        @(negedge aclk);
        steps++;
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({arvalid, araddr, arprot} !== '0) begin n_fail++; $display("FAIL reset_ar: got arvalid=%b araddr=%h arprot=%b, required all 0", arvalid, araddr, arprot); end
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout, stray_err} !== '0) begin n_fail++; $display("FAIL reset_rsp: got valid=%b data=%h resp=%b to=%b stray=%b, required all 0", rsp_valid, rsp_data, rsp_resp, rsp_timeout, stray_err); end
    n_checks++;
    if (rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready: got %b required 1", rready); end
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_priority: got req_ready=%b required 0001", req_ready); end
    req_valid = '0;
    @(negedge aclk);
  endtask
  task automatic test_single_read();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    int steps;
    int c0;
    exp_t e;
    c0 = ar_count;
    set_req(0, 32'h10, 3'b010);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b required 0001", req_ready); end
    do_ar(0, a, p, ok);
    req_valid = '0;
    n_checks++;
    if (!ok || a !== 32'h10 || p !== 3'b010) begin n_fail++; $display("FAIL single_ar: got ok=%0d araddr=%h arprot=%b, required 1 00000010 010", ok, a, p); end
    sb.push_back('{onehot: 4'b0001, data: 32'hDEADBEEF, resp: RESP_OKAY, to: 1'b0});
    do_r(0, 32'hDEADBEEF, RESP_OKAY);
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || steps !== 0 || rsp_valid !== e.onehot) begin n_fail++; $display("FAIL single_rsp_valid: got ok=%0d steps=%0d rsp_valid=%b, required 1 0 %b", ok, steps, rsp_valid, e.onehot); end
    n_checks++;
    if (rsp_data !== e.data || rsp_resp !== e.resp || rsp_timeout !== e.to) begin n_fail++; $display("FAIL single_rsp_data: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.to); end
    @(negedge aclk);
    n_checks++;
    if (rsp_valid !== '0 || ar_count - c0 !== 1) begin n_fail++; $display("FAIL single_once: got rsp_valid=%b ar_count=%0d, required 0000 and 1", rsp_valid, ar_count - c0); end
  endtask
  task automatic test_fairness();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    int steps;
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, AW'((i + 1) * 4), 3'(i));
    for (int k = 0; k < 6; k++) begin
      do_ar(0, a, p, ok);
      n_checks++;
      if (!ok || a !== AW'((k % 3 + 1) * 4) || p !== 3'(k % 3)) begin n_fail++; $display("FAIL fair_ar%0d: got ok=%0d araddr=%h arprot=%b, required addr %h", k, ok, a, p, AW'((k % 3 + 1) * 4)); end
      sb.push_back('{onehot: N'(1) << (k % 3), data: DW'(32'hA000 + k), resp: RESP_OKAY, to: 1'b0});
      do_r(0, DW'(32'hA000 + k), RESP_OKAY);
      if (k == 5) req_valid = '0;
      wait_rsp(steps, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || rsp_valid !== e.onehot || rsp_data !== e.data) begin n_fail++; $display("FAIL fair_rsp%0d: got rsp_valid=%b data=%h, required %b %h", k, rsp_valid, rsp_data, e.onehot, e.data); end
    end
    @(negedge aclk);
  endtask
  task automatic test_ar_backpressure();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    int steps;
    int c0;
    exp_t e;
    c0 = ar_count;
    set_req(0, 32'h40, 3'b101);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge aclk);
      ok = arvalid;
    end
    req_valid = '0;
    set_req(1, 32'h44, 3'b001);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge aclk);
      #1;
      n_checks++;
      if ({arvalid, araddr, arprot} !== {1'b1, 32'h40, 3'b101}) begin n_fail++; $display("FAIL bp_hold%0d: got arvalid=%b araddr=%h arprot=%b, required 1 00000040 101", i, arvalid, araddr, arprot); end
      n_checks++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready%0d: got req_ready=%b required 0000", i, req_ready); end
    end
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    n_checks++;
    if (ar_count - c0 !== 1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got count=%0d arvalid=%b, required 1 0", ar_count - c0, arvalid); end
    sb.push_back('{onehot: 4'b0001, data: 32'h5555AAAA, resp: RESP_OKAY, to: 1'b0});
    do_r(2, 32'h5555AAAA, RESP_OKAY);
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || rsp_valid !== e.onehot || rsp_data !== e.data) begin n_fail++; $display("FAIL bp_rsp0: got rsp_valid=%b data=%h, required %b %h", rsp_valid, rsp_data, e.onehot, e.data); end
    do_ar(0, a, p, ok);
    req_valid = '0;
    n_checks++;
    if (!ok || a !== 32'h44 || p !== 3'b001) begin n_fail++; $display("FAIL bp_ar1: got ok=%0d araddr=%h arprot=%b, required 1 00000044 001", ok, a, p); end
    sb.push_back('{onehot: 4'b0010, data: 32'h0BADF00D, resp: RESP_EXOKAY, to: 1'b0});
    do_r(0, 32'h0BADF00D, RESP_EXOKAY);
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || rsp_valid !== e.onehot || rsp_data !== e.data || rsp_resp !== e.resp) begin n_fail++; $display("FAIL bp_rsp1: got %b %h %b, required %b %h %b", rsp_valid, rsp_data, rsp_resp, e.onehot, e.data, e.resp); end
    @(negedge aclk);
  endtask
  task automatic test_timeout();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    int steps;
    exp_t e;
    set_req(2, 32'h80, 3'b000);
    do_ar(0, a, p, ok);
    req_valid = '0;
    n_checks++;
    if (!ok || a !== 32'h80) begin n_fail++; $display("FAIL to_ar: got ok=%0d araddr=%h, required 1 00000080", ok, a); end
    sb.push_back('{onehot: 4'b0100, data: '0, resp: RESP_SLVERR, to: 1'b1});
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || steps !== TO || rsp_valid !== e.onehot) begin n_fail++; $display("FAIL to_latency: got ok=%0d steps=%0d rsp_valid=%b, required 1 %0d %b", ok, steps, rsp_valid, TO, e.onehot); end
    n_checks++;
    if (rsp_data !== e.data || rsp_resp !== e.resp || rsp_timeout !== e.to) begin n_fail++; $display("FAIL to_rsp: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_resp, rsp_timeout, e.data, e.resp, e.to); end
    @(negedge aclk);
    n_checks++;
    if (stray_err !== 1'b0) begin n_fail++; $display("FAIL to_stray_pre: got %b required 0", stray_err); end
    rvalid = 1'b1;
    rdata = 32'hBAD;
    @(negedge aclk);
    rvalid = 1'b0;
    n_checks++;
    if (stray_err !== 1'b1 || rsp_valid !== '0) begin n_fail++; $display("FAIL to_stray_set: got stray=%b rsp_valid=%b, required 1 0000", stray_err, rsp_valid); end
    repeat (3) @(negedge aclk);
    n_checks++;
    if (stray_err !== 1'b1) begin n_fail++; $display("FAIL to_stray_hold: got %b required 1", stray_err); end
    set_req(2, 32'h84, 3'b000);
    do_ar(0, a, p, ok);
    req_valid = '0;
    sb.push_back('{onehot: 4'b0100, data: 32'h00C0FFEE, resp: RESP_OKAY, to: 1'b0});
    do_r(TO - 1, 32'h00C0FFEE, RESP_OKAY);
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || steps !== 0 || rsp_valid !== e.onehot || rsp_data !== e.data || rsp_resp !== e.resp || rsp_timeout !== e.to) begin n_fail++; $display("FAIL to_edge_rvalid: got ok=%0d %b %h %b %b, required %b %h %b %b", ok, rsp_valid, rsp_data, rsp_resp, rsp_timeout, e.onehot, e.data, e.resp, e.to); end
    @(negedge aclk);
  endtask
  task automatic test_error_passthrough();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    int steps;
    exp_t e;
    set_req(3, 32'hF0, 3'b111);
    do_ar(0, a, p, ok);
    req_valid = '0;
    n_checks++;
    if (!ok || a !== 32'hF0 || p !== 3'b111) begin n_fail++; $display("FAIL err_ar: got ok=%0d araddr=%h arprot=%b, required 1 000000f0 111", ok, a, p); end
    sb.push_back('{onehot: 4'b1000, data: 32'h1234, resp: RESP_DECERR, to: 1'b0});
    do_r(1, 32'h1234, RESP_DECERR);
    wait_rsp(steps, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || rsp_valid !== e.onehot || rsp_data !== e.data || rsp_resp !== e.resp || rsp_timeout !== e.to) begin n_fail++; $display("FAIL err_rsp: got %b %h %b %b, required %b %h %b %b", rsp_valid, rsp_data, rsp_resp, rsp_timeout, e.onehot, e.data, e.resp, e.to); end
    n_checks++;
    if (stray_err !== 1'b1) begin n_fail++; $display("FAIL err_stray_sticky: got %b required 1", stray_err); end
    @(negedge aclk);
  endtask
  task automatic test_reset_mid_data();
    logic [AW-1:0] a;
    logic [2:0] p;
    bit ok;
    set_req(0, 32'h100, 3'b011);
    do_ar(0, a, p, ok);
    req_valid = '0;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    n_checks++;
    if ({arvalid, araddr, arprot, rsp_valid} !== '0 || rready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ar: got arvalid=%b araddr=%h arprot=%b rsp_valid=%b rready=%b, required 0s and rready 1", arvalid, araddr, arprot, rsp_valid, rready); end
    n_checks++;
    if ({rsp_data, rsp_resp, rsp_timeout, stray_err} !== '0) begin n_fail++; $display("FAIL rst_mid_rsp: got data=%h resp=%b to=%b stray=%b, required all 0", rsp_data, rsp_resp, rsp_timeout, stray_err); end
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_priority: got req_ready=%b required 0001", req_ready); end
    req_valid = '0;
    @(negedge aclk);
    n_checks++;
    if (sb.size() !== 0 || rsp_valid !== '0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, rsp_valid=%b, required 0 0000", sb.size(), rsp_valid); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_ar_backpressure();
    test_timeout();
    test_error_passthrough();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
